// File: rtl/router_ingress_arb.sv
// router_ingress_arb: packet-granular round-robin arbiter sharing the router's
// single ingress byte stream between NREQ sources. A grant is held for a whole
// packet. Router backpressure reaches only the granted source. One idle GAP
// cycle follows every packet so that the router sees a fresh pkt_valid edge.
// Optional feature: define ROUTER_ARB_WATCHDOG_EN to build a busy watchdog
// that aborts a grant after WDOG_CYC consecutive router_busy cycles.
module router_ingress_arb #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DW       = 8,
   parameter int unsigned WDOG_CYC = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_pkt_valid,
   input  logic [NREQ*DW-1:0]      req_data,
   output logic [NREQ-1:0]         req_busy,
   input  logic                    router_busy,
   output logic                    router_pkt_valid,
   output logic [DW-1:0]           router_data,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    pkt_done,
   output logic                    wdog_abort
);

   localparam int unsigned    IDW      = $clog2(NREQ);
   localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

   if (NREQ < 2 || NREQ > 8 || WDOG_CYC < 1) begin : g_cfg_err
      $error("router_ingress_arb: NREQ must be 2..8 and WDOG_CYC at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_GAP
   } state_e;

   state_e         state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;
   logic [IDW-1:0]  last_q, last_d;
   logic            pkt_done_q, pkt_done_d;

   logic [DW-1:0]   src_data [NREQ];
   logic            win_found;
   logic [IDW-1:0]  win_id;
   logic [IDW-1:0]  scan_idx;

`ifdef ROUTER_ARB_WATCHDOG_EN
   localparam int unsigned WCW = $clog2(WDOG_CYC + 1);
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic           wdog_abort_q, wdog_abort_d;
`endif

   // Split the flat source data bus into one byte lane per source.
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         src_data[i] = req_data[i*DW +: DW];
      end
   end

   // Round-robin search: first requester at or after last+1, cyclically.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         scan_idx = IDW'((32'(last_q) + k) % NREQ);
         if (!win_found && req_pkt_valid[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   // Combinational datapath mux and per-source backpressure.
   always_comb begin
      router_pkt_valid = 1'b0;
      router_data      = '0;
      req_busy         = '1;
      if (state_q == ST_HOLD) begin
         router_pkt_valid     = req_pkt_valid[grant_id_q];
         router_data          = src_data[grant_id_q];
         req_busy[grant_id_q] = router_busy;
      end
   end

   // Next-state logic: arbitrate in IDLE, hold for a packet, one GAP cycle.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      pkt_done_d = 1'b0;
`ifdef ROUTER_ARB_WATCHDOG_EN
      wcnt_d       = wcnt_q;
      wdog_abort_d = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d         = ST_HOLD;
               grant_d         = '0;
               grant_d[win_id] = 1'b1;
               grant_id_d      = win_id;
               last_d          = win_id;
`ifdef ROUTER_ARB_WATCHDOG_EN
               wcnt_d          = '0;
`endif
            end
         end
         ST_HOLD: begin
            if (!router_busy) begin
`ifdef ROUTER_ARB_WATCHDOG_EN
               wcnt_d = '0;
`endif
               // Valid low with no stall is the accepted parity beat.
               if (!req_pkt_valid[grant_id_q]) begin
                  pkt_done_d = 1'b1;
                  state_d    = ST_GAP;
                  grant_d    = '0;
               end
            end
`ifdef ROUTER_ARB_WATCHDOG_EN
            else if (wcnt_q == WCW'(WDOG_CYC - 1)) begin
               wdog_abort_d = 1'b1;
               state_d      = ST_GAP;
               grant_d      = '0;
               wcnt_d       = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
`endif
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         last_q     <= LAST_RST;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         pkt_done_q <= pkt_done_d;
      end
   end

`ifdef ROUTER_ARB_WATCHDOG_EN
   // Watchdog counter and abort pulse register.
   always_ff @(posedge clock) begin
      if (reset) begin
         wcnt_q       <= '0;
         wdog_abort_q <= 1'b0;
      end else begin
         wcnt_q       <= wcnt_d;
         wdog_abort_q <= wdog_abort_d;
      end
   end

   assign wdog_abort = wdog_abort_q;
`else
   assign wdog_abort = 1'b0;
`endif

   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_router_ingress_arb.sv
// Testbench for router_ingress_arb: randomized and directed packet sources,
// scoreboard of expected forwarded beats per source, and a packet-level
// round-robin reference model checked by an independent monitor.
module tb_router_ingress_arb;

   localparam int unsigned NREQ     = 4;
   localparam int unsigned DW       = 8;
   localparam int unsigned WDOG_CYC = 64;
   localparam int unsigned IDW      = $clog2(NREQ);

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_pkt_valid;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_busy;
   logic                 router_busy;
   logic                 router_pkt_valid;
   logic [DW-1:0]        router_data;
   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       grant_id;
   logic                 pkt_done;
   logic                 wdog_abort;

   router_ingress_arb #(
      .NREQ    (NREQ),
      .DW      (DW),
      .WDOG_CYC(WDOG_CYC)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_pkt_valid   (req_pkt_valid),
      .req_data        (req_data),
      .req_busy        (req_busy),
      .router_busy     (router_busy),
      .router_pkt_valid(router_pkt_valid),
      .router_data     (router_data),
      .grant           (grant),
      .grant_id        (grant_id),
      .pkt_done        (pkt_done),
      .wdog_abort      (wdog_abort)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Scoreboard: expected beats per source, {valid, byte}, pushed at packet start.
   logic [8:0] exp_q [NREQ][$];

   // Source driver state.
   logic [7:0]  pkt_mem [NREQ][0:7];
   int          plen [NREQ];
   int          pidx [NREQ];
   int          pkts_left [NREQ];
   int unsigned start_pct;
   int unsigned busy_pct;
   int unsigned len_lo;
   int unsigned len_hi;
   int          addr_fix;
   logic        busy_script [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor with packet-level reference model: round robin over requesters,
   // one grant per packet, parity accept -> done pulse, GAP, IDLE, next grant.
   initial begin : monitor
      logic            m_init;
      logic            m_busy;
      logic [IDW-1:0]  m_gid;
      logic [IDW-1:0]  m_last;
      int              m_free;
      int              done_cyc;
      int              abort_cyc;
      int              wcnt;
      int              win;
      logic [NREQ-1:0] exp_busy;
      logic [8:0]      front;
      m_init = 1'b0; m_busy = 1'b0; m_gid = '0; m_last = IDW'(NREQ - 1);
      m_free = 0; done_cyc = -1; abort_cyc = -1; wcnt = 0;
      forever begin
         @(negedge clock);
         cyc++;
         if (m_init) begin
            if (m_busy) begin
               exp_busy        = '1;
               exp_busy[m_gid] = router_busy;
               chk("grant", 32'(grant), 32'(1) << m_gid);
               chk("grant_id", 32'(grant_id), 32'(m_gid));
               chk("req_busy", 32'(req_busy), 32'(exp_busy));
               chk("router_pkt_valid", 32'(router_pkt_valid), 32'(req_pkt_valid[m_gid]));
               chk("router_data", 32'(router_data), 32'(req_data[m_gid*DW +: DW]));
            end else begin
               chk("grant_idle", 32'(grant), 32'(0));
               chk("req_busy_idle", 32'(req_busy), 32'({NREQ{1'b1}}));
               chk("router_pkt_valid_idle", 32'(router_pkt_valid), 32'(0));
               chk("router_data_idle", 32'(router_data), 32'(0));
            end
            chk("pkt_done", 32'(pkt_done), 32'(cyc == done_cyc));
            chk("wdog_abort", 32'(wdog_abort), 32'(cyc == abort_cyc));

            if (m_busy) begin
               if (!router_busy) begin
                  wcnt = 0;
                  if (exp_q[m_gid].size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL unexpected_beat at cycle %0d: got 0x%0h from source %0d, expected no beat",
                              cyc, {router_pkt_valid, router_data}, m_gid);
                     if (!router_pkt_valid) begin
                        m_busy = 1'b0; done_cyc = cyc + 1; m_free = cyc + 2;
                     end
                  end else begin
                     front = exp_q[m_gid].pop_front();
                     chk("beat", 32'({router_pkt_valid, router_data}), 32'(front));
                     if (!front[8]) begin
                        m_busy = 1'b0; done_cyc = cyc + 1; m_free = cyc + 2;
                     end
                  end
               end else begin
                  wcnt++;
`ifdef ROUTER_ARB_WATCHDOG_EN
                  if (wcnt == int'(WDOG_CYC)) begin
                     m_busy = 1'b0; abort_cyc = cyc + 1; m_free = cyc + 2; wcnt = 0;
                  end
`endif
               end
            end else if (cyc >= m_free && req_pkt_valid != '0) begin
               for (int k = 1; k <= int'(NREQ); k++) begin
                  win = (int'(m_last) + k) % int'(NREQ);
                  if (((req_pkt_valid >> win) & 1) != 0) break;
               end
               m_gid  = IDW'(win);
               m_last = IDW'(win);
               m_busy = 1'b1;
               wcnt   = 0;
            end
         end
         if (reset) begin
            m_init = 1'b1; m_busy = 1'b0; m_last = IDW'(NREQ - 1);
            m_free = cyc + 1; done_cyc = -1; abort_cyc = -1; wcnt = 0;
            for (int s = 0; s < int'(NREQ); s++) exp_q[s].delete();
         end
      end
   end

   task automatic new_pkt(input int s);
      int unsigned len;
      logic [1:0]  addr;
      logic [7:0]  par;
      len  = $urandom_range(len_hi, len_lo);
      addr = (addr_fix >= 0) ? 2'(addr_fix) : 2'($urandom_range(2, 0));
      pkt_mem[s][0] = {6'(len), addr};
      par = pkt_mem[s][0];
      for (int unsigned i = 1; i <= len; i++) begin
         pkt_mem[s][i] = 8'($urandom);
         par ^= pkt_mem[s][i];
      end
      pkt_mem[s][len+1] = par;
      plen[s] = int'(len) + 2;
      pidx[s] = 0;
      for (int i = 0; i < plen[s]; i++) begin
         exp_q[s].push_back({(i < plen[s] - 1) ? 1'b1 : 1'b0, pkt_mem[s][i]});
      end
   endtask

   task automatic drive_src(input int s);
      if (pidx[s] < plen[s]) begin
         req_pkt_valid[IDW'(s)] = (pidx[s] < plen[s] - 1);
         req_data[s*DW +: DW]   = pkt_mem[s][pidx[s]];
      end else begin
         req_pkt_valid[IDW'(s)] = 1'b0;
         req_data[s*DW +: DW]   = 8'($urandom);
      end
   endtask

   // One clock of stimulus: a beat advances when presented with req_busy low.
   task automatic step();
      logic [NREQ-1:0] acc;
      @(negedge clock);
      for (int s = 0; s < int'(NREQ); s++) begin
         acc[IDW'(s)] = (pidx[s] < plen[s]) && !req_busy[IDW'(s)];
      end
      @(posedge clock);
      #1;
      for (int s = 0; s < int'(NREQ); s++) begin
         if (acc[IDW'(s)]) pidx[s]++;
         if (pidx[s] >= plen[s] && pkts_left[s] > 0 && $urandom_range(99, 0) < start_pct) begin
            new_pkt(s);
            pkts_left[s]--;
         end
         drive_src(s);
      end
      if (busy_script.size() > 0) router_busy = busy_script.pop_front();
      else router_busy = ($urandom_range(99, 0) < busy_pct);
   endtask

   function automatic logic all_idle();
      logic r;
      r = 1'b1;
      for (int s = 0; s < int'(NREQ); s++) begin
         if (pidx[s] < plen[s] || pkts_left[s] > 0 || exp_q[s].size() != 0) r = 1'b0;
      end
      return r;
   endfunction

   task automatic drain();
      int   n;
      logic idle;
      n = 0;
      do begin
         step();
         n++;
         idle = all_idle();
      end while (!idle && n < 2000);
      n_tests++;
      if (!idle) begin
         n_fail++;
         $display("FAIL drain at cycle %0d: got sources still busy after %0d cycles, expected all packets forwarded", cyc, n);
      end
      busy_script.delete();
      repeat (4) step();
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      router_busy = 1'b1;
      @(posedge clock);
      #1;
      reset       = 1'b0;
      router_busy = 1'b0;
      for (int s = 0; s < int'(NREQ); s++) begin
         plen[s] = 0; pidx[s] = 0; pkts_left[s] = 0;
         drive_src(s);
      end
   endtask

   task automatic set_len(input int unsigned lo, input int unsigned hi);
      len_lo = lo;
      len_hi = hi;
   endtask

   initial begin : timeout
      #300000;
      $display("FAIL timeout: got no completion, expected the run to finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset         = 1'b1;
      router_busy   = 1'b0;
      req_pkt_valid = '0;
      req_data      = '0;
      start_pct     = 100;
      busy_pct      = 0;
      addr_fix      = -1;
      set_len(1, 3);
      for (int s = 0; s < int'(NREQ); s++) begin
         plen[s] = 0; pidx[s] = 0; pkts_left[s] = 0;
      end
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) step();

      // Single source 2 packet: header 8'h09, two payload bytes, parity.
      set_len(2, 2);
      addr_fix     = 1;
      pkts_left[2] = 1;
      drain();
      addr_fix = -1;

      // Sources 0,1,3 requesting continuously with 1-byte packets.
      set_len(1, 1);
      pkts_left[0] = 2; pkts_left[1] = 2; pkts_left[3] = 2;
      drain();

      // Five busy cycles in the middle of the payload.
      set_len(2, 2);
      busy_script = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      pkts_left[0] = 1;
      drain();

      // Parity held for three busy cycles.
      set_len(1, 1);
      busy_script = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      pkts_left[1] = 1;
      drain();

      // Reset during the payload of source 1, then sources 0 and 1 request.
      set_len(3, 3);
      pkts_left[1] = 1;
      repeat (4) step();
      do_reset();
      pkts_left[0] = 1; pkts_left[1] = 1;
      drain();

      // Long busy stall: watchdog abort when built in, indefinite hold otherwise.
      set_len(3, 3);
      busy_script = '{1'b0, 1'b0, 1'b0};
      repeat (70) busy_script.push_back(1'b1);
      pkts_left[0] = 1;
      drain();

      // Randomized traffic from all sources with random backpressure.
      set_len(1, 3);
      start_pct = 40;
      busy_pct  = 25;
      for (int s = 0; s < int'(NREQ); s++) pkts_left[s] = 8;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/router_ingress_arb.md
# router_ingress_arb

Packet-granular round-robin arbiter that shares the router's single ingress port (header/payload/parity byte stream plus `pkt_valid`) between `NREQ` upstream sources. It sits in front of the router FSM/register datapath, holds a grant for a whole packet, and forwards the router's `busy` backpressure to the granted source only. It also inserts the idle gap the router FSM needs to detect the next header.

## Interface
- `NREQ`, 4: number of requesting sources, 2..8.
- `DW`, 8: byte width of the packet stream.
- `WDOG_CYC`, 64: watchdog limit in cycles. Used only with `ROUTER_ARB_WATCHDOG_EN`.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_pkt_valid`  in  NREQ  per-source packet valid. High for header and payload; low on the parity beat.
- `req_data`  in  NREQ*DW  per-source data. Source i occupies bits [i*DW +: DW].
- `req_busy`  out  NREQ  per-source stall. Source holds its data while this is high.
- `router_busy`  in  1  busy from the router FSM.
- `router_pkt_valid`  out  1  muxed packet valid to the router.
- `router_data`  out  DW  muxed data to the router.
- `grant`  out  NREQ  one-hot grant, registered.
- `grant_id`  out  $clog2(NREQ)  index of the granted source. Valid while `grant` != 0.
- `pkt_done`  out  1  one-cycle pulse when the parity beat is accepted.
- `wdog_abort`  out  1  one-cycle pulse on watchdog abort. Tied to 0 when the watchdog is compiled out.

## Operation
States:
- **IDLE**
  - `grant` = 0; `router_pkt_valid` = 0; `router_data` = 0.
  - If any `req_pkt_valid` is high, go to HOLD next cycle.
  - Winner: the first requester at or after index `last+1`, searched cyclically.
  - Set `grant`/`grant_id` to the winner and update `last` to the winner.
- **HOLD**
  - `router_pkt_valid` = `req_pkt_valid[grant_id]`; `router_data` = `req_data[grant_id]`.
  - Granted source: `req_busy` = `router_busy`.
  - If `req_pkt_valid[grant_id]` = 0 and `router_busy` = 0, the parity beat is accepted: pulse `pkt_done` and go to GAP.
  - If `req_pkt_valid[grant_id]` = 0 while `router_busy` = 1, stay in HOLD; the source holds parity.
- **GAP**
  - Exactly one cycle with `grant` = 0 and `router_pkt_valid` = 0, then IDLE.
  - Guarantees the router sees a `pkt_valid` 0->1 edge on every header.

Source stalls and ordering:
- Every non-granted source sees `req_busy` = 1 in all states, including IDLE.
- A source whose request is not serviced keeps `req_pkt_valid` and its header stable until granted.
- Round robin: `last` resets to `NREQ-1`, so source 0 wins first. With all sources requesting continuously, the order is 0,1,2,...,NREQ-1,0.
- A source that drops its request while not granted is simply skipped; there is no latched request.

Reset:
- `reset` at any time forces IDLE within one edge and returns `last` to `NREQ-1`.
- All outputs go to their reset values in that same cycle, aborting any packet in flight without a `pkt_done`.

Output reset values:
- `grant` = 0, `grant_id` = 0.
- `req_busy` = all 1.
- `router_pkt_valid` = 0, `router_data` = 0.
- `pkt_done` = 0, `wdog_abort` = 0.

## Timing
- Arbitration latency:
  - Request seen in IDLE at edge n: grant visible after edge n+1.
  - The header reaches `router_data` combinationally in that same cycle.
- The data path is a combinational mux with no pipeline register. There is no added latency between the source and the router while in HOLD.
- `grant`, `grant_id`, `pkt_done`, `wdog_abort` and the state are registered.
- Minimum packet-to-packet spacing: parity accept, one GAP cycle, one IDLE cycle. The next header is therefore presented 3 cycles after the parity cycle.
- The router's `busy` propagates to the granted `req_busy` in the same cycle (combinational).

## Configuration
- `ROUTER_ARB_WATCHDOG_EN` defined:
  - A counter runs in HOLD and increments each cycle `router_busy` = 1. It clears on any cycle with `router_busy` = 0.
  - On reaching `WDOG_CYC`, pulse `wdog_abort` and go to GAP.
  - The granted source sees `req_busy` = 1 from then on until its next grant.
  - The counter clears on entry to HOLD.
- Not defined:
  - No counter is built; `wdog_abort` is tied to 0.
  - HOLD waits indefinitely on `router_busy`.

## Test plan
- Reset, then hold source 2 high with a header of 8'h09 (len 2, addr 1), 2 payload bytes and parity -> `grant` = 4'b0100 one cycle later. Exactly 4 bytes are forwarded, `pkt_done` pulses once, followed by one GAP cycle.
- Sources 0,1,3 request simultaneously and continuously with 1-byte packets -> grant order 0,1,3,0,1,3. Each non-granted `req_busy` stays 1 throughout.
- `router_busy` = 1 for 5 cycles mid-payload -> granted `req_busy` = 1 for exactly those 5 cycles, with `router_data` stable. No `pkt_done` until the parity beat is accepted after busy drops.
- Parity presented while `router_busy` = 1 for 3 cycles -> stay in HOLD. `pkt_done` pulses in the first cycle with `router_busy` = 0.
- Assert `reset` during the payload of source 1 -> next cycle `grant` = 0, `router_pkt_valid` = 0, no `pkt_done`. The next grant goes to source 0 if requesting.
- With `ROUTER_ARB_WATCHDOG_EN` and `WDOG_CYC` = 64, hold `router_busy` = 1 for 64 cycles -> `wdog_abort` pulses in cycle 64 and the arbiter goes to GAP. Without the macro, under the same stimulus, the arbiter stays in HOLD.
